// File: rtl/crf_axil_master.sv
// rtl/crf_axil_master.sv - single-outstanding AXI4-Lite master with response timeout
// and a sticky latch for the upsampling-done interrupt.
module crf_axil_master #(
   parameter int          AXI_DATA_WIDTH = 32,
   parameter int          AXI_ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]                  rsp_resp,
   output logic                        rsp_timeout,
   output logic                        m_axi_awvalid,
   input  logic                        m_axi_awready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [2:0]                  m_axi_awprot,
   output logic                        m_axi_wvalid,
   input  logic                        m_axi_wready,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   input  logic                        m_axi_bvalid,
   output logic                        m_axi_bready,
   input  logic [1:0]                  m_axi_bresp,
   output logic                        m_axi_arvalid,
   input  logic                        m_axi_arready,
   output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [2:0]                  m_axi_arprot,
   input  logic                        m_axi_rvalid,
   output logic                        m_axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]                  m_axi_rresp,
   input  logic                        interrupt_updone,
   output logic                        irq_pending,
   input  logic                        irq_clr
);

   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP} state_t;

   localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

   state_t      state;
   logic [31:0] cnt;
   logic        timeout_hit;
   logic        aw_done;
   logic        w_done;
   logic        irq_d;
   logic        irq_edge;

   assign m_axi_awprot = 3'b000;
   assign m_axi_arprot = 3'b000;

   // Counter value reached on this edge equals TIMEOUT_CYCLES
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);
   assign aw_done     = !m_axi_awvalid || m_axi_awready;
   assign w_done      = !m_axi_wvalid || m_axi_wready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         cmd_ready     <= 1'b0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_resp      <= '0;
         rsp_timeout   <= 1'b0;
         m_axi_awvalid <= 1'b0;
         m_axi_awaddr  <= '0;
         m_axi_wvalid  <= 1'b0;
         m_axi_wdata   <= '0;
         m_axi_wstrb   <= '0;
         m_axi_bready  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_rready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready   <= 1'b0;
                  cnt         <= '0;
                  rsp_timeout <= 1'b0;
                  if (cmd_write) begin
                     m_axi_awaddr  <= cmd_addr;
                     m_axi_wdata   <= cmd_wdata;
                     m_axi_wstrb   <= cmd_wstrb;
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     state         <= WR_REQ;
                  end else begin
                     m_axi_araddr  <= cmd_addr;
                     m_axi_arvalid <= 1'b1;
                     state         <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               cnt <= cnt + 32'd1;
               if (timeout_hit) begin
                  m_axi_awvalid <= 1'b0;
                  m_axi_wvalid  <= 1'b0;
                  rsp_timeout   <= 1'b1;
                  rsp_resp      <= 2'b10;
                  rsp_rdata     <= '0;
                  rsp_valid     <= 1'b1;
                  state         <= RSP;
               end else begin
                  if (m_axi_awready) m_axi_awvalid <= 1'b0;
                  if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                  if (aw_done && w_done) begin
                     m_axi_bready <= 1'b1;
                     state        <= WR_RESP;
                  end
               end
            end
            WR_RESP: begin
               cnt <= cnt + 32'd1;
               // A response landing on the timeout edge still counts as a real response
               if (m_axi_bvalid) begin
                  m_axi_bready <= 1'b0;
                  rsp_resp     <= m_axi_bresp;
                  rsp_rdata    <= '0;
                  rsp_valid    <= 1'b1;
                  state        <= RSP;
               end else if (timeout_hit) begin
                  m_axi_bready <= 1'b0;
                  rsp_timeout  <= 1'b1;
                  rsp_resp     <= 2'b10;
                  rsp_rdata    <= '0;
                  rsp_valid    <= 1'b1;
                  state        <= RSP;
               end
            end
            RD_REQ: begin
               cnt <= cnt + 32'd1;
               if (timeout_hit) begin
                  m_axi_arvalid <= 1'b0;
                  rsp_timeout   <= 1'b1;
                  rsp_resp      <= 2'b10;
                  rsp_rdata     <= '0;
                  rsp_valid     <= 1'b1;
                  state         <= RSP;
               end else if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  m_axi_rready  <= 1'b1;
                  state         <= RD_RESP;
               end
            end
            RD_RESP: begin
               cnt <= cnt + 32'd1;
               if (m_axi_rvalid) begin
                  m_axi_rready <= 1'b0;
                  rsp_resp     <= m_axi_rresp;
                  rsp_rdata    <= m_axi_rdata;
                  rsp_valid    <= 1'b1;
                  state        <= RSP;
               end else if (timeout_hit) begin
                  m_axi_rready <= 1'b0;
                  rsp_timeout  <= 1'b1;
                  rsp_resp     <= 2'b10;
                  rsp_rdata    <= '0;
                  rsp_valid    <= 1'b1;
                  state        <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Edge is registered before it sets the flag, so a set lands two cycles after the pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_d       <= 1'b0;
         irq_edge    <= 1'b0;
         irq_pending <= 1'b0;
      end else begin
         irq_d    <= interrupt_updone;
         irq_edge <= interrupt_updone & ~irq_d;
         if (irq_edge)     irq_pending <= 1'b1;
         else if (irq_clr) irq_pending <= 1'b0;
      end
   end

endmodule
